timepulse_generator: RTL and testbench

Parametrised timing-pulse generator for the AGC simulator core. It produces a one-hot cascade of `NUM_PULSES` timing pulses, one per clock, forming one memory cycle. It adds run/halt control, single-memory-cycle and single-pulse stepping, an end-of-cycle strobe and a completed-cycle counter. Downstream control-pulse decode and memory timing key off `tp`, `eoc` and `cycle_count`.

---
 rtl/timepulse_generator.sv | 104 ++++++++++
 tb/tb_timepulse_generator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timepulse_generator.sv
// One-hot memory-cycle timing pulse generator with run/halt control,
// single-cycle and single-pulse stepping, end-of-cycle strobe and cycle counter.
module timepulse_generator #(
    parameter int NUM_PULSES = 12,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step_req,
    input  logic                  step_mode,
    output logic [NUM_PULSES-1:0] tp,
    output logic                  eoc,
    output logic                  busy,
    output logic [CNT_W-1:0]      cycle_count
);

    localparam int IDX_W = (NUM_PULSES > 2) ? $clog2(NUM_PULSES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PULSES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CYC   = 2'd2,
        PULSE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [IDX_W-1:0]  idx_inc;
    logic              at_last;
    logic              count_inc;
    logic              emit_next;

    assign at_last = (idx == LAST);
    assign idx_inc = at_last ? '0 : idx + IDX_W'(1);

    // While emitting, idx is the pulse being driven this cycle; in IDLE it is
    // the resume point for the next request.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        count_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = RUN;
                end else if (step_req) begin
                    state_next = step_mode ? PULSE : CYC;
                end
            end
            RUN: begin
                idx_next  = idx_inc;
                count_inc = at_last;
                if (at_last && !run) begin
                    state_next = IDLE;
                end
            end
            CYC: begin
                idx_next  = idx_inc;
                count_inc = at_last;
                if (at_last) begin
                    state_next = IDLE;
                end
            end
            PULSE: begin
                idx_next   = idx_inc;
                count_inc  = at_last;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign emit_next = (state_next != IDLE);

    // Outputs are registered from the next-state view so each pulse is
    // visible during the cycle that state represents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            tp          <= '0;
            eoc         <= 1'b0;
            busy        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            tp    <= emit_next ? (NUM_PULSES'(1) << idx_next) : '0;
            eoc   <= emit_next && (idx_next == LAST);
            busy  <= emit_next;
            if (count_inc) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_timepulse_generator.sv
// Directed bench for timepulse_generator: free run, halt, stepping, async
// reset and a narrow-counter wrap instance.
module tb_timepulse_generator;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step_req;
    logic        step_mode;
    logic [11:0] tp;
    logic        eoc;
    logic        busy;
    logic [15:0] cycle_count;

    logic        run2;
    logic [11:0] tp2;
    logic        eoc2;
    logic        busy2;
    logic [1:0]  cycle_count2;

    integer compared;
    integer mismatched;

    timepulse_generator #(.NUM_PULSES(12), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .step_req(step_req),
        .step_mode(step_mode), .tp(tp), .eoc(eoc), .busy(busy),
        .cycle_count(cycle_count)
    );

    timepulse_generator #(.NUM_PULSES(12), .CNT_W(2)) dut_wrap (
        .clk(clk), .reset(reset), .run(run2), .step_req(1'b0),
        .step_mode(1'b0), .tp(tp2), .eoc(eoc2), .busy(busy2),
        .cycle_count(cycle_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset     = 1'b1;
        run       = 1'b0;
        run2      = 1'b0;
        step_req  = 1'b0;
        step_mode = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        compared++;
        if (tp !== 12'h000) begin
            mismatched++;
            $display("[TB] FAIL reset_tp got=%h exp=%h", tp, 12'h000);
        end
        compared++;
        if ({eoc, busy} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_eoc_busy got=%b exp=00", {eoc, busy});
        end
        compared++;
        if (cycle_count !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_count got=%0d exp=0", cycle_count);
        end
        tick();
        compared++;
        if (tp !== 12'h000 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset tp=%h busy=%b exp tp=000 busy=0", tp, busy);
        end
    endtask

    task automatic test_free_run;
        logic [11:0] exp;
        run = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            exp = 12'h001 << (i % 12);
            compared++;
            if (tp !== exp) begin
                mismatched++;
                $display("[TB] FAIL free_tp[%0d] got=%h exp=%h", i, tp, exp);
            end
            compared++;
            if (eoc !== ((i % 12) == 11)) begin
                mismatched++;
                $display("[TB] FAIL free_eoc[%0d] got=%b exp=%b", i, eoc, (i % 12) == 11);
            end
            compared++;
            if (busy !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL free_busy[%0d] got=%b exp=1", i, busy);
            end
        end
        tick();
        compared++;
        if (tp !== 12'h001) begin
            mismatched++;
            $display("[TB] FAIL free_wrap_tp got=%h exp=001", tp);
        end
        compared++;
        if (cycle_count !== 16'd2) begin
            mismatched++;
            $display("[TB] FAIL free_count got=%0d exp=2", cycle_count);
        end
    endtask

    // Continues from test_free_run: tp[0] of the third cycle is showing.
    task automatic test_graceful_halt;
        logic [11:0] exp;
        repeat (4) tick();
        compared++;
        if (tp !== 12'h010) begin
            mismatched++;
            $display("[TB] FAIL halt_tp4 got=%h exp=010", tp);
        end
        run = 1'b0;
        for (int k = 5; k < 12; k++) begin
            tick();
            exp = 12'h001 << k;
            compared++;
            if (tp !== exp || busy !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL halt_tp[%0d] got=%h busy=%b exp=%h busy=1", k, tp, busy, exp);
            end
        end
        tick();
        compared++;
        if (tp !== 12'h000 || busy !== 1'b0 || eoc !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL halt_idle tp=%h busy=%b eoc=%b exp tp=000 busy=0 eoc=0", tp, busy, eoc);
        end
        compared++;
        if (cycle_count !== 16'd3) begin
            mismatched++;
            $display("[TB] FAIL halt_count got=%0d exp=3", cycle_count);
        end
    endtask

    task automatic test_pulse_step;
        logic [11:0] exp;
        apply_reset();
        tick();
        step_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            exp = 12'h001 << k;
            compared++;
            if (tp !== exp || busy !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL pstep_tp[%0d] got=%h busy=%b exp=%h busy=1", k, tp, busy, exp);
            end
            tick();
            compared++;
            if (tp !== 12'h000 || busy !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL pstep_gap[%0d] tp=%h busy=%b exp tp=000 busy=0", k, tp, busy);
            end
            tick();
        end
        step_mode = 1'b0;
        run = 1'b1;
        for (int k = 3; k < 12; k++) begin
            tick();
            exp = 12'h001 << k;
            compared++;
            if (tp !== exp || eoc !== (k == 11)) begin
                mismatched++;
                $display("[TB] FAIL resume_tp[%0d] got=%h eoc=%b exp=%h eoc=%b", k, tp, eoc, exp, k == 11);
            end
        end
        run = 1'b0;
        tick();
        compared++;
        if (tp !== 12'h000 || cycle_count !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL resume_end tp=%h count=%0d exp tp=000 count=1", tp, cycle_count);
        end
    endtask

    task automatic test_cycle_step;
        logic [11:0] exp;
        step_mode = 1'b0;
        step_req  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            step_req = (k == 5);
            exp = 12'h001 << k;
            compared++;
            if (tp !== exp || busy !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL cstep_tp[%0d] got=%h busy=%b exp=%h busy=1", k, tp, busy, exp);
            end
        end
        step_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if (tp !== 12'h000 || busy !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL cstep_idle[%0d] tp=%h busy=%b exp tp=000 busy=0", k, tp, busy);
            end
        end
        compared++;
        if (cycle_count !== 16'd2) begin
            mismatched++;
            $display("[TB] FAIL cstep_count got=%0d exp=2", cycle_count);
        end
    endtask

    task automatic test_async_reset;
        run = 1'b1;
        repeat (8) tick();
        compared++;
        if (tp !== 12'h080 || cycle_count !== 16'd2) begin
            mismatched++;
            $display("[TB] FAIL areset_pre tp=%h count=%0d exp tp=080 count=2", tp, cycle_count);
        end
        #3;
        reset = 1'b1;
        #1;
        compared++;
        if (tp !== 12'h000 || eoc !== 1'b0 || busy !== 1'b0 || cycle_count !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL areset_now tp=%h eoc=%b busy=%b count=%0d exp all 0", tp, eoc, busy, cycle_count);
        end
        tick();
        reset = 1'b0;
        tick();
        compared++;
        if (tp !== 12'h001 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL areset_resume tp=%h busy=%b exp tp=001 busy=1", tp, busy);
        end
        run = 1'b0;
    endtask

    task automatic test_counter_wrap;
        logic [1:0] exp;
        apply_reset();
        run2 = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            repeat (12) tick();
            exp = 2'(c % 4);
            compared++;
            if (cycle_count2 !== exp || tp2 !== 12'h001) begin
                mismatched++;
                $display("[TB] FAIL wrap_count[%0d] got=%0d tp=%h exp=%0d tp=001", c, cycle_count2, tp2, exp);
            end
        end
        run2 = 1'b0;
        repeat (12) tick();
        compared++;
        if (busy2 !== 1'b0 || eoc2 !== 1'b0 || cycle_count2 !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL wrap_halt busy=%b eoc=%b count=%0d exp busy=0 eoc=0 count=2", busy2, eoc2, cycle_count2);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        run        = 1'b0;
        run2       = 1'b0;
        step_req   = 1'b0;
        step_mode  = 1'b0;
        test_reset();
        test_free_run();
        test_graceful_halt();
        test_pulse_step();
        test_cycle_step();
        test_async_reset();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
